// File: rtl/ifm_issue_sched.sv
// rtl/ifm_issue_sched.sv - IFM buffer read sequencer with 2-entry skid FIFO onto the ifm_port stream.
// Optional perf counters enabled by defining IFM_SCHED_PERF_EN.
module ifm_issue_sched #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8,
    parameter int TILE_W = 10,
    parameter int DATA_W = 576,
    parameter int LANES  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_inter_len,
    input  logic [LEN_W-1:0]  cfg_accum_len,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    input  logic [LANES-1:0]  cfg_lane_mask,
    output logic              busy,
    output logic              done,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              ifm_valid,
    input  logic              ifm_ready,
    output logic [DATA_W-1:0] ifm_data,
    output logic [LANES-1:0]  ifm_elem_valid,
    output logic              ifm_inter_end,
    output logic              ifm_accum_end
`ifdef IFM_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_beat_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    inter_q, accum_q, beat_q, grp_q;
    logic [TILE_W-1:0]   tiles_q, tile_q;
    logic [LANES-1:0]    mask_q;
    logic                inflight_q, pend_ie_q, pend_ae_q;
    logic [DATA_W-1:0]   fifo_data_q [2];
    logic                fifo_ie_q   [2];
    logic                fifo_ae_q   [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          count_q;

    logic start_ok, zero_job, issue, issue_ie, issue_ae, last_read, pop;

    assign start_ok  = cfg_start && (state_q == S_IDLE);
    assign zero_job  = (cfg_inter_len == '0) || (cfg_accum_len == '0) || (cfg_num_tiles == '0);
    // Credit: an in-flight read always has a FIFO slot waiting for it.
    assign issue     = (state_q == S_RUN) && ((count_q + {1'b0, inflight_q}) < 2'd2);
    assign issue_ie  = (beat_q == inter_q - LEN_W'(1));
    assign issue_ae  = issue_ie && (grp_q == accum_q - LEN_W'(1));
    assign last_read = issue_ae && (tile_q == tiles_q - TILE_W'(1));
    assign pop       = ifm_valid && ifm_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = zero_job ? S_DONE : S_RUN;
            S_RUN:   if (issue && last_read) state_d = S_DRAIN;
            // Leave as the final beat is accepted so done follows it by one cycle.
            S_DRAIN: if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign buf_rd_en      = issue;
    assign buf_rd_addr    = addr_q;
    assign ifm_valid      = (count_q != 2'd0);
    assign ifm_data       = fifo_data_q[rd_ptr_q];
    assign ifm_inter_end  = ifm_valid && fifo_ie_q[rd_ptr_q];
    assign ifm_accum_end  = ifm_valid && fifo_ae_q[rd_ptr_q];
    assign ifm_elem_valid = ifm_valid ? mask_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inter_q    <= '0;
            accum_q    <= '0;
            tiles_q    <= '0;
            mask_q     <= '0;
            beat_q     <= '0;
            grp_q      <= '0;
            tile_q     <= '0;
            inflight_q <= 1'b0;
            pend_ie_q  <= 1'b0;
            pend_ae_q  <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_ie_q[0]   <= 1'b0;
            fifo_ie_q[1]   <= 1'b0;
            fifo_ae_q[0]   <= 1'b0;
            fifo_ae_q[1]   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            pend_ie_q  <= issue_ie;
            pend_ae_q  <= issue_ae;
            if (start_ok) begin
                addr_q  <= cfg_base_addr;
                inter_q <= cfg_inter_len;
                accum_q <= cfg_accum_len;
                tiles_q <= cfg_num_tiles;
                mask_q  <= cfg_lane_mask;
                beat_q  <= '0;
                grp_q   <= '0;
                tile_q  <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (issue_ie) begin
                    beat_q <= '0;
                    if (issue_ae) begin
                        grp_q  <= '0;
                        tile_q <= tile_q + TILE_W'(1);
                    end else begin
                        grp_q <= grp_q + LEN_W'(1);
                    end
                end else begin
                    beat_q <= beat_q + LEN_W'(1);
                end
            end
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= buf_rd_data;
                fifo_ie_q[wr_ptr_q]   <= pend_ie_q;
                fifo_ae_q[wr_ptr_q]   <= pend_ae_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(inflight_q) - 2'(pop);
        end
    end

`ifdef IFM_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_beat_cnt  <= '0;
        end else if (start_ok) begin
            perf_stall_cnt <= '0;
            perf_beat_cnt  <= '0;
        end else begin
            if (ifm_valid && !ifm_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (pop && (perf_beat_cnt != '1))
                perf_beat_cnt <= perf_beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifm_issue_sched.sv
// tb/tb_ifm_issue_sched.sv - directed self-checking bench for ifm_issue_sched.
module tb_ifm_issue_sched;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 8;
    localparam int TILE_W = 10;
    localparam int DATA_W = 576;
    localparam int LANES  = 64;

    logic              clk, rst_n, cfg_start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [LEN_W-1:0]  cfg_inter_len, cfg_accum_len;
    logic [TILE_W-1:0] cfg_num_tiles;
    logic [LANES-1:0]  cfg_lane_mask;
    logic              busy, done, buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;
    logic              ifm_valid, ifm_ready;
    logic [DATA_W-1:0] ifm_data;
    logic [LANES-1:0]  ifm_elem_valid;
    logic              ifm_inter_end, ifm_accum_end;
`ifdef IFM_SCHED_PERF_EN
    logic [31:0]       perf_stall_cnt, perf_beat_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int last_stalls = 0;

    ifm_issue_sched dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_inter_len(cfg_inter_len),
        .cfg_accum_len(cfg_accum_len), .cfg_num_tiles(cfg_num_tiles),
        .cfg_lane_mask(cfg_lane_mask), .busy(busy), .done(done),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
        .ifm_elem_valid(ifm_elem_valid), .ifm_inter_end(ifm_inter_end),
        .ifm_accum_end(ifm_accum_end)
`ifdef IFM_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_beat_cnt(perf_beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: data is the address replicated; a junk pattern when no read was issued.
    always @(posedge clk)
        buf_rd_data <= buf_rd_en ? {48{buf_rd_addr}} : {48{12'hBAD}};

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, DATA_W'(busy), 0);
        check_val({tag, "_done"}, DATA_W'(done), 0);
        check_val({tag, "_rd_en"}, DATA_W'(buf_rd_en), 0);
        check_val({tag, "_rd_addr"}, DATA_W'(buf_rd_addr), 0);
        check_val({tag, "_valid"}, DATA_W'(ifm_valid), 0);
        check_val({tag, "_data"}, ifm_data, 0);
        check_val({tag, "_elem"}, DATA_W'(ifm_elem_valid), 0);
        check_val({tag, "_tags"}, DATA_W'({ifm_inter_end, ifm_accum_end}), 0);
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input int inter, input int accum,
                           input int tiles, input bit toggle, input bit inject,
                           input logic [LANES-1:0] mask);
        int total, k, issued, first, last_acc, done_cyc, stalls;
        bit holding;
        logic [DATA_W-1:0] held;
        logic [ADDR_W-1:0] ea;
        total = inter * accum * tiles;
        k = 0; issued = 0; first = -1; last_acc = -1; done_cyc = -1; stalls = 0; holding = 0;
        held = '0;
        @(negedge clk);
        cfg_base_addr = base;
        cfg_inter_len = LEN_W'(inter);
        cfg_accum_len = LEN_W'(accum);
        cfg_num_tiles = TILE_W'(tiles);
        cfg_lane_mask = mask;
        cfg_start     = 1'b1;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            cfg_start = inject && (cyc == 2);
            if (inject) cfg_base_addr = base + 12'h100;
            ifm_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (buf_rd_en) begin
                ea = base + ADDR_W'(issued);
                check_val("rd_addr", DATA_W'(buf_rd_addr), DATA_W'(ea));
                issued++;
            end
            if (holding) begin
                check_val("stall_valid", DATA_W'(ifm_valid), 1);
                check_val("stall_data", ifm_data, held);
                holding = 0;
            end
            if (ifm_valid && first < 0) first = cyc;
            if (ifm_valid && !ifm_ready) begin
                held = ifm_data;
                holding = 1;
                stalls++;
            end
            if (ifm_valid && ifm_ready) begin
                ea = base + ADDR_W'(k);
                check_val("beat_data", ifm_data, {48{ea}});
                check_val("inter_end", DATA_W'(ifm_inter_end), DATA_W'((k % inter) == inter - 1));
                check_val("accum_end", DATA_W'(ifm_accum_end),
                          DATA_W'((k % (inter * accum)) == inter * accum - 1));
                check_val("elem_valid", DATA_W'(ifm_elem_valid), DATA_W'(mask));
                k++;
                last_acc = cyc;
            end
            if (!ifm_valid) check_val("elem_idle", DATA_W'(ifm_elem_valid), 0);
            if (done) done_cyc = cyc;
        end
        check_val("latency", DATA_W'(first), 3);
        check_val("beat_count", DATA_W'(k), DATA_W'(total));
        check_val("read_count", DATA_W'(issued), DATA_W'(total));
        check_val("done_gap", DATA_W'(done_cyc), DATA_W'(last_acc + 1));
        @(negedge clk);
        ifm_ready = 1'b1;
        #1;
        check_val("busy_after", DATA_W'(busy), 0);
        last_stalls = stalls;
    endtask

    initial begin
        int acc;
        int rd_seen;
        rst_n = 1'b0; cfg_start = 1'b0; ifm_ready = 1'b1;
        cfg_base_addr = '0; cfg_inter_len = '0; cfg_accum_len = '0;
        cfg_num_tiles = '0; cfg_lane_mask = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // T1
        run_job(12'h010, 3, 2, 1, 1'b0, 1'b0, 64'hF0F0_1234_5678_9ABC);
        // T2
        run_job(12'h040, 4, 1, 3, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF);
`ifdef IFM_SCHED_PERF_EN
        check_val("perf_beat", DATA_W'(perf_beat_cnt), 12);
        check_val("perf_stall", DATA_W'(perf_stall_cnt), DATA_W'(last_stalls));
`endif
        // T3 address wrap
        run_job(12'hFFE, 4, 1, 1, 1'b0, 1'b0, 64'h8000_0000_0000_0001);

        // T4 zero-length job
        @(negedge clk);
        cfg_base_addr = 12'h123; cfg_inter_len = 8'd0; cfg_accum_len = 8'd2;
        cfg_num_tiles = 10'd1; cfg_start = 1'b1;
        rd_seen = 0;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        if (buf_rd_en) rd_seen++;
        check_val("zero_busy", DATA_W'(busy), 1);
        check_val("zero_done", DATA_W'(done), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (buf_rd_en) rd_seen++;
            check_val("zero_busy_end", DATA_W'(busy), 0);
            check_val("zero_done_end", DATA_W'(done), 0);
        end
        check_val("zero_reads", DATA_W'(rd_seen), 0);
        // T4 second start while busy must be ignored
        run_job(12'h080, 2, 2, 1, 1'b0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F);

        // T5 reset mid-job
        @(negedge clk);
        cfg_base_addr = 12'h200; cfg_inter_len = 8'd16; cfg_accum_len = 8'd1;
        cfg_num_tiles = 10'd1; cfg_lane_mask = '1; cfg_start = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 60 && acc < 5; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            ifm_ready = 1'b1;
            #1;
            if (ifm_valid && ifm_ready) acc++;
        end
        check_val("abort_progress", DATA_W'(acc), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_val("abort_no_done", DATA_W'(done), 0);
            check_val("abort_no_valid", DATA_W'(ifm_valid), 0);
        end
        rst_n = 1'b1;
        run_job(12'h300, 3, 1, 2, 1'b0, 1'b0, 64'h1111_2222_3333_4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
